// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared widths, stall encoding, reset PC and hold FSM states for the fetch stage
package if_fetch_unit_pkg;
  localparam int STALL_W = 6;
  localparam int IF_TO_ID_WD = 33;
  localparam int BR_WD = 33;
  localparam logic [31:0] RESET_PC = 32'hBFBF_FFFC;
  localparam logic STOP = 1'b1;
  localparam logic NO_STOP = 1'b0;
  localparam int STALL_PC = 0;
  localparam int STALL_IF = 1;
  localparam int STALL_ID = 2;
  typedef enum logic {RUN, HOLD} hold_state_e;
  function automatic logic misaligned(input logic [31:0] a);
    return a[1:0] != 2'b00;
  endfunction
endpackage

// File: rtl/if_fetch_unit_inst_hold.sv
// if_inst_hold: keeps the instruction word stable for decode while the ID stage is stalled
module if_inst_hold
  import if_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_id,
  input  logic [31:0] rdata,
  output logic [31:0] id_inst
);
  hold_state_e state, state_nx;
  logic        hold_vld, capture;
  logic [31:0] hold_inst;
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    capture = 1'b0;
    if (state == RUN) begin
      capture = stall_id == STOP;
      state_nx = capture ? HOLD : RUN;
    end else begin
      state_nx = stall_id == NO_STOP ? RUN : HOLD;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld <= 1'b0;
      hold_inst <= 32'b0;
    end else begin
      hold_vld <= state_nx == HOLD;
      if (capture) hold_inst <= rdata;
    end
  end
  assign id_inst = hold_vld ? hold_inst : rdata;
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: owns the PC, drives the instruction SRAM and presents {ce, pc} plus a stall-stable word to decode
module if_fetch_unit
  import if_fetch_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_W-1:0]     stall,
  input  logic [BR_WD-1:0]       br_bus,
  output logic                   inst_sram_en,
  output logic [3:0]             inst_sram_wen,
  output logic [31:0]            inst_sram_addr,
  output logic [31:0]            inst_sram_wdata,
  input  logic [31:0]            inst_sram_rdata,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic [31:0]            id_inst,
  output logic                   fetch_adel
);
  logic [31:0] pc_reg, redir_pc, next_pc, br_addr;
  logic        ce_reg, redir_vld, br_e, unused_stall;
  assign {br_e, br_addr} = br_bus;
  assign next_pc = br_e ? br_addr : redir_vld ? redir_pc : pc_reg + 32'd4;
  // A branch seen while the PC is frozen is parked until the stall lifts; the newest one wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= RESET_PC;
      ce_reg <= 1'b0;
      redir_vld <= 1'b0;
      redir_pc <= 32'b0;
    end else if (stall[STALL_PC] == NO_STOP) begin
      pc_reg <= next_pc;
      ce_reg <= 1'b1;
      redir_vld <= 1'b0;
    end else if (br_e) begin
      redir_vld <= 1'b1;
      redir_pc <= br_addr;
    end
  end
  if_inst_hold u_hold (
    .clk      (clk),
    .rst      (rst),
    .stall_id (stall[STALL_ID]),
    .rdata    (inst_sram_rdata),
    .id_inst  (id_inst)
  );
  assign inst_sram_en = ce_reg;
  assign inst_sram_wen = 4'b0000;
  assign inst_sram_addr = pc_reg;
  assign inst_sram_wdata = 32'b0;
  assign if_to_id_bus = {ce_reg, pc_reg};
  assign fetch_adel = ce_reg & misaligned(pc_reg);
  assign unused_stall = ^{stall[STALL_W-1:STALL_ID+1], stall[STALL_IF]};
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: scenario tasks against a synchronous SRAM model with an expected-word scoreboard
module tb_if_fetch_unit;
  logic        clk, rst, inst_sram_en, fetch_adel, use_ovr;
  logic [5:0]  stall;
  logic [32:0] br_bus, if_to_id_bus;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata, id_inst, ovr;
  logic [31:0] sb_q[$];
  int total = 0;
  int bad = 0;
  localparam logic [31:0] RST_PC = 32'hBFBF_FFFC;

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .br_bus(br_bus),
    .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata), .if_to_id_bus(if_to_id_bus),
    .id_inst(id_inst), .fetch_adel(fetch_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0F0F;
  endfunction

  always @(posedge clk) begin
    if (use_ovr) inst_sram_rdata <= ovr;
    else if (inst_sram_en) inst_sram_rdata <= word_of(inst_sram_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; stall = 0; br_bus = 0; use_ovr = 0; ovr = 0; inst_sram_rdata = 32'h0;
    tick(); tick();
    total++; if (inst_sram_addr !== RST_PC) begin bad++; $display("FAIL reset_addr: got %h want %h", inst_sram_addr, RST_PC); end
    total++; if (inst_sram_en !== 1'b0) begin bad++; $display("FAIL reset_en: got %b want 0", inst_sram_en); end
    total++; if (if_to_id_bus !== {1'b0, RST_PC}) begin bad++; $display("FAIL reset_bus: got %h want %h", if_to_id_bus, {1'b0, RST_PC}); end
    total++; if (fetch_adel !== 1'b0) begin bad++; $display("FAIL reset_adel: got %b want 0", fetch_adel); end
    total++; if (inst_sram_wen !== 4'b0 || inst_sram_wdata !== 32'b0) begin bad++; $display("FAIL reset_wr: got %h/%h want 0/0", inst_sram_wen, inst_sram_wdata); end
    total++; if (id_inst !== inst_sram_rdata) begin bad++; $display("FAIL reset_inst: got %h want %h", id_inst, inst_sram_rdata); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr, w;
    exp_addr = 32'hBFC0_0000;
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (if_to_id_bus !== {1'b1, exp_addr}) begin bad++; $display("FAIL seq_bus%0d: got %h want %h", i, if_to_id_bus, {1'b1, exp_addr}); end
      total++; if (inst_sram_addr !== exp_addr || inst_sram_en !== 1'b1) begin bad++; $display("FAIL seq_addr%0d: got %h en %b want %h en 1", i, inst_sram_addr, inst_sram_en, exp_addr); end
      if (sb_q.size() > 0) begin
        w = sb_q.pop_front();
        total++; if (id_inst !== w) begin bad++; $display("FAIL seq_inst%0d: got %h want %h", i, id_inst, w); end
      end
      sb_q.push_back(word_of(exp_addr));
      exp_addr += 32'd4;
    end
  endtask

  task automatic test_branch();
    logic [31:0] w;
    br_bus = {1'b1, 32'hBFC0_0100};
    tick();
    br_bus = 0;
    total++; if (inst_sram_addr !== 32'hBFC0_0100) begin bad++; $display("FAIL br_addr: got %h want BFC00100", inst_sram_addr); end
    w = sb_q.pop_front();
    total++; if (id_inst !== w) begin bad++; $display("FAIL br_delay_slot: got %h want %h", id_inst, w); end
    sb_q.push_back(word_of(32'hBFC0_0100));
    tick();
    total++; if (inst_sram_addr !== 32'hBFC0_0104) begin bad++; $display("FAIL br_next: got %h want BFC00104", inst_sram_addr); end
    w = sb_q.pop_front();
    total++; if (id_inst !== w) begin bad++; $display("FAIL br_target_inst: got %h want %h", id_inst, w); end
    sb_q.delete();
  endtask

  task automatic test_stall_redirect();
    stall = 6'b000001; br_bus = {1'b1, 32'hBFC0_0200};
    tick();
    br_bus = 0;
    total++; if (inst_sram_addr !== 32'hBFC0_0104) begin bad++; $display("FAIL stall_hold1: got %h want BFC00104", inst_sram_addr); end
    tick(); tick();
    total++; if (inst_sram_addr !== 32'hBFC0_0104) begin bad++; $display("FAIL stall_hold3: got %h want BFC00104", inst_sram_addr); end
    stall = 0;
    tick();
    total++; if (inst_sram_addr !== 32'hBFC0_0200) begin bad++; $display("FAIL redir_addr: got %h want BFC00200", inst_sram_addr); end
    tick();
    total++; if (inst_sram_addr !== 32'hBFC0_0204) begin bad++; $display("FAIL redir_clear: got %h want BFC00204", inst_sram_addr); end
  endtask

  task automatic test_back_to_back();
    stall = 6'b000001; br_bus = {1'b1, 32'hBFC0_0280};
    tick();
    br_bus = {1'b1, 32'hBFC0_02C0};
    tick();
    br_bus = 0;
    tick();
    stall = 0;
    tick();
    total++; if (inst_sram_addr !== 32'hBFC0_02C0) begin bad++; $display("FAIL latest_br: got %h want BFC002C0", inst_sram_addr); end
    stall = 6'b000001; br_bus = {1'b1, 32'hBFC0_0400};
    tick();
    stall = 0; br_bus = {1'b1, 32'hBFC0_0500};
    tick();
    br_bus = 0;
    total++; if (inst_sram_addr !== 32'hBFC0_0500) begin bad++; $display("FAIL br_over_redir: got %h want BFC00500", inst_sram_addr); end
    tick();
    total++; if (inst_sram_addr !== 32'hBFC0_0504) begin bad++; $display("FAIL br_over_redir_next: got %h want BFC00504", inst_sram_addr); end
  endtask

  task automatic test_hold();
    logic [31:0] a;
    use_ovr = 1; ovr = 32'h2408_0005;
    tick();
    a = inst_sram_addr;
    total++; if (id_inst !== 32'h2408_0005) begin bad++; $display("FAIL hold_pre: got %h want 24080005", id_inst); end
    stall = 6'b000111; ovr = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (id_inst !== 32'h2408_0005 || inst_sram_addr !== a) begin bad++; $display("FAIL hold_cyc%0d: got %h addr %h want 24080005 addr %h", i, id_inst, inst_sram_addr, a); end
    end
    stall = 0;
    tick();
    total++; if (id_inst !== 32'hDEAD_BEEF || inst_sram_addr !== a + 32'd4) begin bad++; $display("FAIL hold_release: got %h addr %h want DEADBEEF addr %h", id_inst, inst_sram_addr, a + 32'd4); end
  endtask

  task automatic test_bubble();
    logic [31:0] a;
    ovr = 32'h1111_2222;
    tick();
    a = inst_sram_addr;
    stall = 6'b000011; ovr = 32'h3333_4444;
    tick();
    total++; if (inst_sram_addr !== a || id_inst !== 32'h3333_4444) begin bad++; $display("FAIL bubble: got %h addr %h want 33334444 addr %h", id_inst, inst_sram_addr, a); end
    stall = 0;
    tick();
    total++; if (inst_sram_addr !== a + 32'd4 || id_inst !== 32'h3333_4444) begin bad++; $display("FAIL bubble_after: got %h addr %h want 33334444 addr %h", id_inst, inst_sram_addr, a + 32'd4); end
  endtask

  task automatic test_reset_hold();
    stall = 6'b000111; br_bus = {1'b1, 32'hBFC0_0300}; ovr = 32'h7777_8888;
    tick();
    total++; if (id_inst !== 32'h3333_4444) begin bad++; $display("FAIL rh_hold: got %h want 33334444", id_inst); end
    rst = 1; br_bus = 0; ovr = 32'h5555_6666;
    tick();
    total++; if (inst_sram_addr !== RST_PC || inst_sram_en !== 1'b0 || fetch_adel !== 1'b0) begin bad++; $display("FAIL rh_pc: got %h en %b adel %b want %h en 0 adel 0", inst_sram_addr, inst_sram_en, fetch_adel, RST_PC); end
    total++; if (id_inst !== 32'h5555_6666) begin bad++; $display("FAIL rh_inst: got %h want 55556666", id_inst); end
    rst = 0; stall = 0; use_ovr = 0;
    tick();
    total++; if (inst_sram_addr !== 32'hBFC0_0000) begin bad++; $display("FAIL rh_redir: got %h want BFC00000", inst_sram_addr); end
    tick();
    total++; if (id_inst !== word_of(32'hBFC0_0000)) begin bad++; $display("FAIL rh_run: got %h want %h", id_inst, word_of(32'hBFC0_0000)); end
  endtask

  task automatic test_adel();
    total++; if (fetch_adel !== 1'b0) begin bad++; $display("FAIL adel_aligned: got %b want 0", fetch_adel); end
    br_bus = {1'b1, 32'hBFC0_0102};
    tick();
    br_bus = 0;
    total++; if (inst_sram_addr !== 32'hBFC0_0102 || fetch_adel !== 1'b1) begin bad++; $display("FAIL adel_set: got %h adel %b want BFC00102 adel 1", inst_sram_addr, fetch_adel); end
    tick();
    total++; if (inst_sram_addr !== 32'hBFC0_0106 || fetch_adel !== 1'b1) begin bad++; $display("FAIL adel_next: got %h adel %b want BFC00106 adel 1", inst_sram_addr, fetch_adel); end
    br_bus = {1'b1, 32'hFFFF_FFFC};
    tick();
    br_bus = 0;
    total++; if (inst_sram_addr !== 32'hFFFF_FFFC || fetch_adel !== 1'b0) begin bad++; $display("FAIL adel_clear: got %h adel %b want FFFFFFFC adel 0", inst_sram_addr, fetch_adel); end
    tick();
    total++; if (inst_sram_addr !== 32'h0000_0000) begin bad++; $display("FAIL pc_wrap: got %h want 00000000", inst_sram_addr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall_redirect();
    test_back_to_back();
    test_hold();
    test_bubble();
    test_reset_hold();
    test_adel();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
